crc32_word_engine: RTL
======================

CRC32_WORD_ENGINE -- requirements
Module: crc32_word_engine

Interface
REQ-001 SHALL have parameter INIT, default 32'hFFFFFFFF, CRC register preset applied on start-of-packet.
REQ-002 SHALL have parameter XOROUT, default 32'hFFFFFFFF, final XOR applied to the published CRC.
REQ-003 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  input word present.
REQ-006 SHALL have port in_ready  output  1  engine accepts the word this cycle.
REQ-007 SHALL have port in_data  input  32  message bytes, byte 0 = in_data[7:0], processed first.
REQ-008 SHALL have port in_sop  input  1  word is the first of a frame.
REQ-009 SHALL have port in_eop  input  1  word is the last of a frame.
REQ-010 SHALL have port in_nbytes  input  2  valid bytes in the eop word, 0 means 4, low bytes valid, ignored when in_eop=0.
REQ-011 SHALL have port crc_valid  output  1  one-cycle pulse, crc_out is new.
REQ-012 SHALL have port crc_out  output  32  finished CRC, held until the next result.

Function
REQ-013 SHALL compute reflected CRC-32, polynomial 32'hEDB88320.
REQ-014 SHALL complete a transfer when in_valid & in_ready are high on a rising edge; in_ready SHALL NOT depend combinationally on in_valid.
REQ-015 SHALL implement FSM states IDLE, RUN and TAIL; in_ready=1 in IDLE and RUN, 0 in TAIL.
REQ-016 SHALL, in IDLE, accept and discard words without in_sop.
REQ-017 SHALL, for any accepted in_sop word in any state, seed the CRC with INIT before applying that word; a sop in RUN abandons the old frame with no crc_valid.
REQ-018 SHALL update a full word in one cycle: x = crc ^ in_data, crc' = T3[x[7:0]] ^ T2[x[15:8]] ^ T1[x[23:16]] ^ T0[x[31:24]].
REQ-019 SHALL define the tables as: T0 = standard byte table; Tk[n] = (Tk-1[n] >> 8) ^ T0[Tk-1[n][7:0]].
REQ-020 SHALL, for eop with in_nbytes=0, pulse crc_valid the next cycle with crc_out = crc' ^ XOROUT, then return to IDLE.
REQ-021 SHALL, for eop with in_nbytes=n (1..3), latch the word and enter TAIL.
REQ-022 SHALL, in TAIL, process one byte per cycle: crc = (crc >> 8) ^ T0[(crc ^ b)[7:0]].
REQ-023 SHALL, for a partial eop word accepted in cycle k, pulse crc_valid in cycle k+n+1, then enter IDLE.
REQ-024 SHALL accept a new word in the same cycle crc_valid pulses.
REQ-025 SHALL treat a non-eop, non-sop word in RUN as a full 4-byte update.
REQ-026 SHALL treat an in_sop & in_eop word as a single-word frame.

Reset
REQ-027 SHALL on rstn low force state IDLE, crc register INIT, crc_valid 0, crc_out 0, in_ready 1 after deassertion.
REQ-028 SHALL abandon a frame interrupted by reset, including one in TAIL, with no crc_valid.

Structure
REQ-029 SHALL place POLY, the FSM state enum and the table-generation function in shared package crc_pkg.
REQ-030 SHALL use sub-module crc32_slice_rom: parameter SLICE (0..3), 8-bit address, 32-bit combinational read data, contents generated at elaboration, four instances.
REQ-031 SHALL have the TAIL byte step reuse the SLICE=0 instance through an address mux.

Verification
REQ-032 SHALL check "123456789": 32'h34333231 sop, 32'h38373635, 32'h00000039 eop nbytes=1 -> crc_out 32'hCBF43926, crc_valid 2 cycles after the last accept.
REQ-033 SHALL check a single word 32'h00000000 with sop+eop, nbytes=0 -> crc_out 32'h2144DF1C, next cycle.
REQ-034 SHALL check a single byte 32'h00000061 with sop+eop, nbytes=1 -> crc_out 32'hE8B7BE43.
REQ-035 SHALL check in_valid held high through TAIL (nbytes=3) -> in_ready 0 for 3 cycles, no word lost, next frame correct.
REQ-036 SHALL check rstn pulsed while in TAIL -> no crc_valid, crc_out 0, next "123456789" frame gives 32'hCBF43926.
REQ-037 SHALL check sop mid-frame, then the "a" frame -> only 32'hE8B7BE43 reported.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared definitions for the word-wide reflected CRC-32 engine: polynomial,
// FSM state encoding and the slice-by-4 table generator used at elaboration.
package crc_pkg;

  localparam logic [31:0] POLY = 32'hEDB88320;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  function automatic logic [31:0] crc_byte_entry(input logic [7:0] n);
    logic [31:0] c;
    c = {24'd0, n};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 5'd1) ^ POLY) : (c >> 5'd1);
    end
    return c;
  endfunction

  // Slice k advances a byte's contribution by k further byte positions.
  function automatic logic [31:0] crc_table_entry(input int slice, input logic [7:0] n);
    logic [31:0] t;
    t = crc_byte_entry(n);
    for (int k = 1; k <= slice; k++) begin
      t = (t >> 5'd8) ^ crc_byte_entry(t[7:0]);
    end
    return t;
  endfunction

endpackage

// File: rtl/crc32_slice_rom.sv
// One 256x32 slice table of the slice-by-4 CRC-32; contents fixed at elaboration,
// combinational read.
module crc32_slice_rom
  import crc_pkg::*;
#(
  parameter int SLICE = 0
) (
  input  logic [7:0]  addr,
  output logic [31:0] data
);

  logic [31:0] table_s [256];

  for (genvar i = 0; i < 256; i++) begin : g_entry
    localparam logic [31:0] ENTRY = crc_table_entry(SLICE, 8'(i));
    assign table_s[i] = ENTRY;
  end

  assign data = table_s[addr];

endmodule

// File: rtl/crc32_word_engine.sv
// Reflected CRC-32 over 32-bit words (byte 0 in the low lane), one word per cycle,
// with a byte-serial tail for partial last words.
module crc32_word_engine
  import crc_pkg::*;
#(
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [1:0]  in_nbytes,
  output logic        crc_valid,
  output logic [31:0] crc_out
);

  state_t      state_r, state_nxt_s;
  logic [31:0] crc_r, crc_nxt_s;
  logic [23:0] tail_data_r, tail_data_nxt_s;
  logic [1:0]  tail_cnt_r, tail_cnt_nxt_s;
  logic        ready_r, valid_r, pulse_s;
  logic [31:0] out_r, result_s;

  logic        accept_s;
  logic [31:0] crc_base_s, x_s, word_crc_s, byte_crc_s;
  logic [7:0]  addr0_s;
  logic [31:0] d0_s, d1_s, d2_s, d3_s;

  assign accept_s   = in_valid & ready_r;
  assign crc_base_s = in_sop ? INIT : crc_r;
  assign x_s        = crc_base_s ^ in_data;

  // Slice-0 table serves the word update's top lane or the tail byte step.
  always_comb begin
    addr0_s = x_s[31:24];
    if (state_r == ST_TAIL) begin
      addr0_s = crc_r[7:0] ^ tail_data_r[7:0];
    end else begin
      addr0_s = x_s[31:24];
    end
  end

  crc32_slice_rom #(.SLICE(0)) u_rom0 (.addr(addr0_s),    .data(d0_s));
  crc32_slice_rom #(.SLICE(1)) u_rom1 (.addr(x_s[23:16]), .data(d1_s));
  crc32_slice_rom #(.SLICE(2)) u_rom2 (.addr(x_s[15:8]),  .data(d2_s));
  crc32_slice_rom #(.SLICE(3)) u_rom3 (.addr(x_s[7:0]),   .data(d3_s));

  assign word_crc_s = d3_s ^ d2_s ^ d1_s ^ d0_s;
  assign byte_crc_s = {8'd0, crc_r[31:8]} ^ d0_s;

  // Next-state, CRC update and result selection.
  always_comb begin
    state_nxt_s     = state_r;
    crc_nxt_s       = crc_r;
    tail_data_nxt_s = tail_data_r;
    tail_cnt_nxt_s  = tail_cnt_r;
    pulse_s         = 1'b0;
    result_s        = out_r;
    case (state_r)
      ST_IDLE, ST_RUN: begin
        if (accept_s && (in_sop || (state_r == ST_RUN))) begin
          if (in_eop && (in_nbytes == 2'd0)) begin
            state_nxt_s = ST_IDLE;
            crc_nxt_s   = word_crc_s;
            pulse_s     = 1'b1;
            result_s    = word_crc_s ^ XOROUT;
          end else if (in_eop) begin
            state_nxt_s     = ST_TAIL;
            crc_nxt_s       = crc_base_s;
            tail_data_nxt_s = in_data[23:0];
            tail_cnt_nxt_s  = in_nbytes;
          end else begin
            state_nxt_s = ST_RUN;
            crc_nxt_s   = word_crc_s;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_TAIL: begin
        crc_nxt_s       = byte_crc_s;
        tail_data_nxt_s = {8'd0, tail_data_r[23:8]};
        tail_cnt_nxt_s  = tail_cnt_r - 2'd1;
        if (tail_cnt_r == 2'd1) begin
          state_nxt_s = ST_IDLE;
          pulse_s     = 1'b1;
          result_s    = byte_crc_s ^ XOROUT;
        end else begin
          state_nxt_s = ST_TAIL;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; in_ready is registered from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      crc_r       <= INIT;
      tail_data_r <= 24'd0;
      tail_cnt_r  <= 2'd0;
      ready_r     <= 1'b1;
      valid_r     <= 1'b0;
      out_r       <= 32'd0;
    end else begin
      state_r     <= state_nxt_s;
      crc_r       <= crc_nxt_s;
      tail_data_r <= tail_data_nxt_s;
      tail_cnt_r  <= tail_cnt_nxt_s;
      ready_r     <= (state_nxt_s != ST_TAIL);
      valid_r     <= pulse_s;
      out_r       <= result_s;
    end
  end

  assign in_ready  = ready_r;
  assign crc_valid = valid_r;
  assign crc_out   = out_r;

endmodule
